// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter for the audio codec DAC.
//
// Buffers 16-bit stereo sample pairs in a small FIFO and serialises one
// pair per frame. bclk and lrclk are divided down from clk; data lags
// lrclk by one bclk and changes on the bclk falling edge.
//
// Ports:
//   clk, reset_n         system clock, async active-low reset
//   enable               1 = run serial clocks, 0 = idle (outputs low)
//   in_valid/in_ready    sample pair handshake (in_ready = FIFO not full)
//   in_left/in_right     16-bit two's complement samples
//   bclk, lrclk, sdata   serial interface to codec (lrclk 0 = left)
//   sample_req           1-clk pulse on every frame load attempt
//   underrun/underrun_clr  sticky empty-at-load flag and its clear
//   fifo_level           FIFO occupancy
//
// Build option: define I2S_TX_HOLD_EN to repeat the last popped pair on
// an underrun load instead of sending zeros.

module i2s_tx #(
    parameter int BCLK_DIV   = 4,
    parameter int SLOT_BITS  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [15:0]                   in_left,
    input  logic [15:0]                   in_right,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          sample_req,
    output logic                          underrun,
    input  logic                          underrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV_W   = $clog2(BCLK_DIV);
    localparam int FRAME_W = 2 * SLOT_BITS;
    localparam int BIT_W   = $clog2(FRAME_W);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   div_nxt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_nxt;
    logic [FRAME_W-1:0] frame_sr;
    logic [FRAME_W-1:0] frame_word;

    logic [31:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic               fifo_empty;
    logic               fifo_full;
    logic               do_push;
    logic               do_pop;
    logic [31:0]        load_pair;

    logic               fall_tick;
    logic               frame_load;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign fifo_level = wr_ptr - rd_ptr;
    assign in_ready   = !fifo_full;

    assign fall_tick  = enable && (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign div_nxt    = fall_tick ? '0 : div_cnt + 1'b1;
    assign bit_nxt    = (bit_cnt == BIT_W'(FRAME_W - 1)) ? '0 : bit_cnt + 1'b1;
    assign frame_load = fall_tick && (bit_nxt == BIT_W'(1));

    // Pop decision uses occupancy before this cycle's push: no bypass.
    assign do_push    = in_valid && !fifo_full;
    assign do_pop     = frame_load && !fifo_empty;

`ifdef I2S_TX_HOLD_EN
    logic [31:0] last_pair;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pair <= '0;
        end else if (do_pop) begin
            last_pair <= fifo_mem[rd_ptr[PTR_W-1:0]];
        end
    end

    assign load_pair = fifo_empty ? last_pair : fifo_mem[rd_ptr[PTR_W-1:0]];
`else
    assign load_pair = fifo_empty ? 32'd0 : fifo_mem[rd_ptr[PTR_W-1:0]];
`endif

    // Left sample in the upper slot, right in the lower slot, each padded
    // with zeros below its LSB out to SLOT_BITS.
    assign frame_word = (FRAME_W'(load_pair[31:16]) << (FRAME_W - 16)) |
                        (FRAME_W'(load_pair[15:0])  << (SLOT_BITS - 16));

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {in_left, in_right};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            frame_sr   <= '0;
            bclk       <= 1'b0;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            sample_req <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            sample_req <= frame_load;

            if (frame_load && fifo_empty) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end

            if (!enable) begin
                div_cnt  <= '0;
                bit_cnt  <= '0;
                frame_sr <= '0;
                bclk     <= 1'b0;
                lrclk    <= 1'b0;
                sdata    <= 1'b0;
            end else begin
                div_cnt <= div_nxt;
                // bclk tracks the new divider value so its falling edge
                // coincides with the data update.
                bclk    <= (div_nxt >= DIV_W'(BCLK_DIV / 2));
                if (fall_tick) begin
                    bit_cnt <= bit_nxt;
                    lrclk   <= (bit_nxt >= BIT_W'(SLOT_BITS));
                    if (frame_load) begin
                        frame_sr <= frame_word;
                        sdata    <= frame_word[FRAME_W-1];
                    end else begin
                        frame_sr <= frame_sr << 1;
                        sdata    <= frame_sr[FRAME_W-2];
                    end
                end
            end
        end
    end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Audio-side I2S transmitter that consumes 16-bit stereo sample pairs from the tone/sample generators and serialises them to the external audio codec DAC.
- Generates bclk and lrclk from clk.
- Buffers sample pairs in a small FIFO with a valid/ready input handshake.
- Emits one sample request per frame and flags underruns.

Parameters:
- BCLK_DIV, 4: clk cycles per bclk period; even, >=2.
- SLOT_BITS, 16: bclk cycles per channel slot; >=16. Bits past bit 16 of a slot are padded with 0.
- FIFO_DEPTH, 4: sample-pair entries; power of 2, >=2.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- enable  in  1  1 = run serial clocks; 0 = idle, outputs held low
- in_valid  in  1  sample pair valid
- in_ready  out  1  FIFO can accept (= !full)
- in_left  in  16  left sample, two's complement
- in_right  in  16  right sample, two's complement
- bclk  out  1  bit clock to codec
- lrclk  out  1  word select; 0 = left, 1 = right
- sdata  out  1  serial data, MSB first
- sample_req  out  1  1-clk pulse per frame-start load attempt
- underrun  out  1  sticky: a frame load found the FIFO empty
- underrun_clr  in  1  clears underrun
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset reset_n, asynchronous, active-low; clock clk. All state is on posedge clk.
- Reset values: bclk=0, lrclk=0, sdata=0, sample_req=0, underrun=0, in_ready=1, fifo_level=0. Internal: div_cnt=0, bit_cnt=0, frame_sr=0, FIFO pointers=0.
- Reset mid-operation discards FIFO contents and the frame in progress.
- FIFO:
  - Push when in_valid && in_ready. Pop only at a frame load.
  - No bypass: a push and a pop on an empty FIFO in the same cycle means the pop sees empty (underrun) and the pushed entry remains.
  - A pop and a push in the same cycle on a non-empty FIFO leaves fifo_level unchanged.
  - FIFO contents are unaffected by enable.
- Clock generation (enable=1):
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - bclk is registered: 1 iff div_cnt >= BCLK_DIV/2.
  - A fall tick is a cycle with div_cnt == BCLK_DIV-1.
- On each fall tick (all updates take effect at the next edge, together with div_cnt -> 0):
  - bit_cnt increments modulo 2*SLOT_BITS.
  - lrclk <= (new bit_cnt >= SLOT_BITS).
  - If new bit_cnt == 1 (frame load):
    - sample_req pulses for 1 clk.
    - Pop pair P if FIFO non-empty; otherwise P = 0 and underrun is set.
    - frame_sr <= {P.left, zero pad, P.right, zero pad}, each half SLOT_BITS wide.
    - sdata <= P.left[15].
  - Otherwise: frame_sr shifts left by 1 and sdata <= the new MSB.
  - Net effect is standard I2S: data lags lrclk by one bclk and changes on the bclk falling edge. Left MSB appears at bit_cnt=1; right MSB appears at bit_cnt=SLOT_BITS+1; right LSB padding finishes at bit_cnt=0 of the next frame.
- Frame length = 2*SLOT_BITS*BCLK_DIV clk cycles (128 at defaults).
- enable=0:
  - div_cnt, bit_cnt and frame_sr are cleared.
  - bclk, lrclk and sdata are driven 0 on the next edge.
  - No sample_req and no pops.
  - Dropping enable mid-frame aborts the frame; the already-popped pair is lost.
  - On enable 0->1, the first fall tick occurs BCLK_DIV cycles later and starts a new frame at the left slot.
- underrun: if set and underrun_clr occur in the same cycle, set wins. Otherwise underrun_clr clears it.

Optional Feature:
- Macro: I2S_TX_HOLD_EN.
- Defined:
  - A separate last-pair register (reset 0) is updated on every successful pop.
  - An underrun load uses the last pair instead of 0 (holds the last sample, avoids clicks).
  - underrun is still set.
- Undefined: the register is absent and an underrun load transmits zeros.

Test Plan:
- Reset: assert reset_n=0 at any point, including mid-frame with FIFO=3 -> all outputs 0 immediately, in_ready=1, fifo_level=0; after release with enable=1, first frame is an underrun frame.
- Single frame (defaults): push L=16'hA5A5, R=16'h0F0F, then enable=1 -> first fall tick 4 clks after enable; sample_req pulse; left bits 1010_0101_1010_0101 on bit_cnt 1..16; lrclk rises at bit_cnt 16; right bits 0000_1111_0000_1111 on bit_cnt 17..31 and 0; fifo_level 1->0.
- Backpressure: enable=0, push 5 pairs back-to-back -> in_ready falls after the 4th push; 5th not accepted; fifo_level=4. Then enable=1 -> pairs transmitted in order, one per 128 clks.
- Underrun: enable=1 with FIFO empty -> sample_req each frame; sdata=0 for the whole frame (with I2S_TX_HOLD_EN: repeats last pair); underrun=1 until an underrun_clr pulse; clr in the same cycle as a new underrun leaves underrun=1.
- Disable mid-frame: drop enable at bit_cnt 8 -> bclk/lrclk/sdata = 0 on the next edge; FIFO retained. Re-enable -> the next pair starts with the left MSB at bit_cnt 1.
- Simultaneous push/pop: push on the exact cycle of a load with FIFO empty -> underrun frame; pushed pair sent in the following frame. Same with FIFO=2 -> fifo_level stays 2.
